// File: rtl/mul_shiftadd_core.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, start/rdy handshake.
// Optional macro MUL_SIGNED_EN selects two's-complement operands with a sign-magnitude datapath.
module mul_shiftadd_core #(
  parameter int X_WIDTH = 3,
  parameter int Y_WIDTH = 3,
  parameter int P_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] p,
  output logic               s,
  output logic               busy,
  output logic               rdy
);

  localparam int CNT_W = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Y_WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (P_WIDTH != X_WIDTH + Y_WIDTH) begin : g_width_check
    $error("mul_shiftadd_core: P_WIDTH must equal X_WIDTH + Y_WIDTH");
  end

  logic [1:0]         state;
  logic [P_WIDTH-1:0] acc;
  logic [X_WIDTH-1:0] mcand;
  logic [Y_WIDTH-1:0] mplier;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               last;
  logic [X_WIDTH-1:0] x_mag;
  logic [Y_WIDTH-1:0] y_mag;
  logic [P_WIDTH-1:0] addend;
  logic [P_WIDTH-1:0] acc_next;
  logic [P_WIDTH-1:0] p_final;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last     = (state == RUN) && (cnt == LAST_CNT);
  assign addend   = mplier[0] ? ({{Y_WIDTH{1'b0}}, mcand} << cnt) : '0;
  assign acc_next = acc + addend;

`ifdef MUL_SIGNED_EN
  logic neg;
  logic s_final;

  // The most-negative operand negates to itself, which reads correctly as an unsigned magnitude.
  assign x_mag   = x[X_WIDTH-1] ? -x : x;
  assign y_mag   = y[Y_WIDTH-1] ? -y : y;
  assign p_final = neg ? -acc_next : acc_next;
  assign s_final = neg && (acc_next != '0);
`else
  assign x_mag   = x;
  assign y_mag   = y;
  assign p_final = acc_next;
  assign s       = 1'b0;
`endif

  // NOTE: reset is synchronous, so it is just the highest-priority branch of the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      p      <= '0;
      busy   <= 1'b0;
      rdy    <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg    <= 1'b0;
      s      <= 1'b0;
`endif
    end else if (accept) begin
      state  <= RUN;
      acc    <= '0;
      mcand  <= x_mag;
      mplier <= y_mag;
      cnt    <= '0;
      busy   <= 1'b1;
      rdy    <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg    <= x[X_WIDTH-1] ^ y[Y_WIDTH-1];
`endif
    end else if (state == RUN) begin
      // NOTE: non-blocking updates let every register see the pre-edge acc/mplier/cnt together.
      acc    <= acc_next;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        p     <= p_final;
        busy  <= 1'b0;
        rdy   <= 1'b1;
`ifdef MUL_SIGNED_EN
        s     <= s_final;
`endif
      end
    end
  end

endmodule
